hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath.
- Detects load-use hazards, HI/LO hazards from the multi-cycle mult/div unit, and taken branches resolved in EX.
- Drives the PC write enable, the IF/ID write enable and flush, and the `bubble` select of the hazard mux that zeroes the ID/EX control bundle.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_BITS, 5, register specifier width.
- MULDIV_LAT, 4, mult/div latency in cycles from EX entry to HI/LO readable in ID; legal range is 1 or more.
- CNT_W, 16, stall counter width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- idex_memread  input  1  instruction in EX is a load
- idex_rt  input  REG_BITS  destination rt of the instruction in EX
- ifid_rs  input  REG_BITS  rs of the instruction in ID
- ifid_rt  input  REG_BITS  rt of the instruction in ID
- ifid_uses_rt  input  1  ID instruction reads rt as a source
- ifid_reads_hilo  input  1  ID instruction is mfhi or mflo
- ifid_is_muldiv  input  1  ID instruction is mult, multu, div or divu
- muldiv_start  input  1  a mult/div is in EX this cycle (one-cycle pulse)
- branch_taken  input  1  branch or jump in EX resolved taken
- pc_write  output  1  PC load enable
- ifid_write  output  1  IF/ID register load enable
- ifid_flush  output  1  clear IF/ID to a NOP at the next edge
- bubble  output  1  hazard mux control; 1 zeroes the EX, MEM and WB control bundles
- md_busy  output  1  mult/div result not yet readable
- stall_count  output  CNT_W  number of stall cycles

Behaviour:
- Control outputs (`pc_write`, `ifid_write`, `ifid_flush`, `bubble`) are combinational from the inputs and registered state; there is no added latency.
- Registered state:
  - FSM state, IDLE or MD_BUSY.
  - md_cnt, clog2(MULDIV_LAT+1) bits wide.
  - stall_count.
- Reset (synchronous, highest priority):
  - At the edge: state=IDLE, md_cnt=0, stall_count=0.
  - While reset is high, outputs are pc_write=0, ifid_write=0, ifid_flush=1, bubble=1, md_busy=0.
- Load-use hazard (lu): idex_memread AND idex_rt != 0 AND (idex_rt == ifid_rs OR (ifid_uses_rt AND idex_rt == ifid_rt)).
- HI/LO hazard (hh): state == MD_BUSY AND (ifid_reads_hilo OR ifid_is_muldiv).
- stall = lu OR hh.
- Output priority:
  1. branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, bubble=1. Squashes the wrong-path ID instruction; overrides any stall.
  2. stall: pc_write=0, ifid_write=0, ifid_flush=0, bubble=1.
  3. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, bubble=0.
- A load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM, idex_memread is clear (the bubble is in EX) and forwarding covers the dependency.
- FSM:
  - IDLE: on muldiv_start with MULDIV_LAT >= 2, go to MD_BUSY with md_cnt = MULDIV_LAT-1. With MULDIV_LAT = 1, stay in IDLE.
  - MD_BUSY: md_cnt decrements every cycle, independent of stalls. When md_cnt == 1, go to IDLE.
  - muldiv_start while in MD_BUSY reloads md_cnt = MULDIV_LAT-1 (restart) and stays in MD_BUSY.
  - Net effect: md_busy=1 for exactly MULDIV_LAT-1 cycles after the start cycle.
- md_busy = (state == MD_BUSY).
- branch_taken does not cancel an in-flight mult/div; the op in EX is architecturally older than the branch target.
- stall_count increments on each edge where stall=1, branch_taken=0 and reset=0. It saturates at 2^CNT_W-1 with no wrap.
- A register specifier of 0 never causes a load-use stall.

Test Plan:
- Reset check: hold reset 2 cycles with random inputs -> pc_write=0, ifid_write=0, ifid_flush=1, bubble=1 during reset; stall_count=0 and md_busy=0 after release.
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 -> exactly one cycle of pc_write=0, ifid_write=0, bubble=1; stall_count=1. Repeat with idex_rt=0 -> no stall.
- rt path: idex_rt=9, ifid_rt=9 -> stall when ifid_uses_rt=1; no stall when ifid_uses_rt=0.
- Mult/div: MULDIV_LAT=4, muldiv_start pulse at cycle t, ifid_reads_hilo=1 held -> bubble=1 and md_busy=1 in cycles t+1..t+3; released at t+4; stall_count=3.
- Branch priority: lu=1 and branch_taken=1 in the same cycle -> pc_write=1, ifid_flush=1, bubble=1; stall_count unchanged.
- Saturation and restart:
  - CNT_W=2, 5 consecutive stall cycles -> stall_count holds at 3.
  - Second muldiv_start at t+2 -> md_busy stays high through t+5.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit_if
// Description : Pipeline-side signal bundle of the hazard control unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_control_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16
);
    logic                idex_memread;
    logic [REG_BITS-1:0] idex_rt;
    logic [REG_BITS-1:0] ifid_rs;
    logic [REG_BITS-1:0] ifid_rt;
    logic                ifid_uses_rt;
    logic                ifid_reads_hilo;
    logic                ifid_is_muldiv;
    logic                muldiv_start;
    logic                branch_taken;
    logic                pc_write;
    logic                ifid_write;
    logic                ifid_flush;
    logic                bubble;
    logic                md_busy;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               ifid_reads_hilo, ifid_is_muldiv, muldiv_start, branch_taken,
        input  pc_write, ifid_write, ifid_flush, bubble, md_busy, stall_count
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               ifid_reads_hilo, ifid_is_muldiv, muldiv_start, branch_taken,
        output pc_write, ifid_write, ifid_flush, bubble, md_busy, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Load-use / HI-LO / taken-branch hazard control for the
//               5-stage MIPS pipeline, with a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
    parameter int REG_BITS   = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_control_unit_if.slave bus
);
    localparam int              MD_W      = $clog2(MULDIV_LAT + 1);
    localparam logic [MD_W-1:0] MD_RELOAD = MD_W'(MULDIV_LAT - 1);
    localparam logic [MD_W-1:0] MD_ONE    = MD_W'(1);
    localparam bit              MD_MULTI  = (MULDIV_LAT >= 2);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MD_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MD_W-1:0]  r_md_cnt;
    logic [MD_W-1:0]  w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_lu;
    logic w_hh;
    logic w_stall;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_bubble;

    // Register 0 is hardwired, so a load targeting it creates no dependency.
    assign w_lu = bus.idex_memread
                && (bus.idex_rt != REG_BITS'(0))
                && ((bus.idex_rt == bus.ifid_rs)
                    || (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

    assign w_hh    = (r_state == S_MD_BUSY) && (bus.ifid_reads_hilo || bus.ifid_is_muldiv);
    assign w_stall = w_lu || w_hh;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_md_cnt      <= '0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (w_stall && !bus.branch_taken && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_bubble     = 1'b0;

        // The mult/div countdown runs regardless of stalls and branches.
        case (r_state)
            S_IDLE: begin
                if (bus.muldiv_start && MD_MULTI) begin
                    w_state_nxt  = S_MD_BUSY;
                    w_md_cnt_nxt = MD_RELOAD;
                end
            end
            S_MD_BUSY: begin
                if (bus.muldiv_start) begin
                    w_md_cnt_nxt = MD_RELOAD;
                end else if (r_md_cnt == MD_ONE) begin
                    w_state_nxt  = S_IDLE;
                    w_md_cnt_nxt = '0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - MD_ONE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_md_cnt_nxt = '0;
            end
        endcase

        if (reset) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_bubble     = 1'b1;
        end else if (bus.branch_taken) begin
            w_ifid_flush = 1'b1;
            w_bubble     = 1'b1;
        end else if (w_stall) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.bubble      = w_bubble;
    assign bus.md_busy     = (r_state == S_MD_BUSY) && !reset;
    assign bus.stall_count = r_stall_count;
endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed + random bench for two hazard_control_unit configs
//               against a cycle-indexed behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;
    localparam int LAT_A = 4;
    localparam int CNT_A = 16;
    localparam int LAT_B = 2;
    localparam int CNT_B = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       mr, urt, rh, md, st, br;
    logic [4:0] drt, rs, rt;

    always #5 clock = ~clock;

    hazard_control_unit_if #(.REG_BITS(5), .CNT_W(CNT_A)) bus_a ();
    hazard_control_unit_if #(.REG_BITS(5), .CNT_W(CNT_B)) bus_b ();

    assign bus_a.idex_memread = mr;   assign bus_b.idex_memread = mr;
    assign bus_a.idex_rt = drt;       assign bus_b.idex_rt = drt;
    assign bus_a.ifid_rs = rs;        assign bus_b.ifid_rs = rs;
    assign bus_a.ifid_rt = rt;        assign bus_b.ifid_rt = rt;
    assign bus_a.ifid_uses_rt = urt;  assign bus_b.ifid_uses_rt = urt;
    assign bus_a.ifid_reads_hilo = rh; assign bus_b.ifid_reads_hilo = rh;
    assign bus_a.ifid_is_muldiv = md; assign bus_b.ifid_is_muldiv = md;
    assign bus_a.muldiv_start = st;   assign bus_b.muldiv_start = st;
    assign bus_a.branch_taken = br;   assign bus_b.branch_taken = br;

    hazard_control_unit #(.REG_BITS(5), .MULDIV_LAT(LAT_A), .CNT_W(CNT_A)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    hazard_control_unit #(.REG_BITS(5), .MULDIV_LAT(LAT_B), .CNT_W(CNT_B)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_start [2] = '{-1000, -1000};
    int count      [2] = '{0, 0};
    int lat        [2] = '{LAT_A, LAT_B};
    int cmax       [2] = '{(1 << CNT_A) - 1, (1 << CNT_B) - 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Busy window: the cycles 1..LAT-1 after the most recent start.
    task automatic eval_cycle();
        bit          lu, busy, stall;
        logic [31:0] o_pc, o_iw, o_fl, o_bb, o_mb, o_sc;
        logic        e_pc, e_iw, e_fl, e_bb;
        lu = mr && (drt != 0) && ((drt == rs) || (urt && (drt == rt)));
        for (int i = 0; i < 2; i++) begin
            busy  = !reset && (cyc - last_start[i] >= 1) && (cyc - last_start[i] <= lat[i] - 1);
            stall = !reset && (lu || (busy && (rh || md)));
            if (reset)         {e_pc, e_iw, e_fl, e_bb} = 4'b0011;
            else if (br)       {e_pc, e_iw, e_fl, e_bb} = 4'b1111;
            else if (stall)    {e_pc, e_iw, e_fl, e_bb} = 4'b0001;
            else               {e_pc, e_iw, e_fl, e_bb} = 4'b1100;
            if (i == 0) begin
                o_pc = 32'(bus_a.pc_write);  o_iw = 32'(bus_a.ifid_write);
                o_fl = 32'(bus_a.ifid_flush); o_bb = 32'(bus_a.bubble);
                o_mb = 32'(bus_a.md_busy);   o_sc = 32'(bus_a.stall_count);
            end else begin
                o_pc = 32'(bus_b.pc_write);  o_iw = 32'(bus_b.ifid_write);
                o_fl = 32'(bus_b.ifid_flush); o_bb = 32'(bus_b.bubble);
                o_mb = 32'(bus_b.md_busy);   o_sc = 32'(bus_b.stall_count);
            end
            check($sformatf("pc_write[%0d]", i),    o_pc, 32'(e_pc));
            check($sformatf("ifid_write[%0d]", i),  o_iw, 32'(e_iw));
            check($sformatf("ifid_flush[%0d]", i),  o_fl, 32'(e_fl));
            check($sformatf("bubble[%0d]", i),      o_bb, 32'(e_bb));
            check($sformatf("md_busy[%0d]", i),     o_mb, 32'(busy));
            check($sformatf("stall_count[%0d]", i), o_sc, 32'(count[i]));
            if (reset) begin
                count[i]      = 0;
                last_start[i] = -1000;
            end else begin
                if (stall && !br && count[i] < cmax[i]) count[i]++;
                if (st && lat[i] >= 2) last_start[i] = cyc;
            end
        end
        cyc++;
    endtask

    task automatic apply(input logic r, input logic m, input logic [4:0] a_drt,
                         input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_urt,
                         input logic a_rh, input logic a_md, input logic a_st, input logic a_br);
        @(negedge clock);
        reset = r; mr = m; drt = a_drt; rs = a_rs; rt = a_rt;
        urt = a_urt; rh = a_rh; md = a_md; st = a_st; br = a_br;
        #1;
        eval_cycle();
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; mr = 0; drt = 0; rs = 0; rt = 0;
        urt = 0; rh = 0; md = 0; st = 0; br = 0;

        repeat (2) apply(1, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle();
        check("rst_count", 32'(bus_a.stall_count), 0);
        check("rst_busy", 32'(bus_a.md_busy), 0);

        // Load-use on rs, then the bubble has reached EX.
        apply(0, 1, 8, 8, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 8, 8, 0, 0, 0, 0, 0, 0);
        check("lu_count", 32'(bus_a.stall_count), 1);
        apply(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        check("lu_zero_pc", 32'(bus_a.pc_write), 1);

        apply(0, 1, 9, 3, 9, 1, 0, 0, 0, 0);
        check("rt_stall", 32'(bus_a.bubble), 1);
        apply(0, 1, 9, 3, 9, 0, 0, 0, 0, 0);
        check("rt_nostall", 32'(bus_a.bubble), 0);

        do_reset();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        repeat (3) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("md_release", 32'(bus_a.bubble), 0);
        check("md_count", 32'(bus_a.stall_count), 3);

        apply(0, 1, 8, 8, 0, 0, 0, 0, 0, 1);
        check("br_flush", 32'(bus_a.ifid_flush), 1);
        idle();
        check("br_count", 32'(bus_a.stall_count), 3);

        do_reset();
        repeat (5) apply(0, 1, 7, 7, 0, 0, 0, 0, 0, 0);
        idle();
        check("sat_count_b", 32'(bus_b.stall_count), 3);
        check("sat_count_a", 32'(bus_a.stall_count), 5);

        do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) idle();
        check("restart_busy_t5", 32'(bus_a.md_busy), 1);
        idle();
        check("restart_idle_t6", 32'(bus_a.md_busy), 0);

        for (int k = 0; k < 600; k++) begin
            apply(($urandom_range(0, 49) == 0), 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
